// File: rtl/demux_pkg.sv
// Shared types and helpers for the buffered 1-to-N stream demultiplexer.
package demux_pkg;

    typedef enum logic {
        MODE_UNICAST = 1'b0,
        MODE_BCAST   = 1'b1
    } demux_mode_t;

    // Select width for a given channel count; never narrower than one bit.
    function automatic int sel_width(input int channels);
        return (channels <= 1) ? 1 : $clog2(channels);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Per-channel synchronous FIFO with wrap-bit pointers and a zeroed read port when empty.
module sync_fifo #(
    parameter int N     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [N-1:0] wdata,
    output logic [N-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wptr_q, wptr_d;
    logic [AW:0]  rptr_q, rptr_d;
    logic [N-1:0] mem_q [DEPTH];
    logic         push_ok, pop_ok;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    assign wptr_d = wptr_q + {{AW{1'b0}}, push_ok};
    assign rptr_d = rptr_q + {{AW{1'b0}}, pop_ok};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: the read port is masked while empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q[AW-1:0]] <= wdata;
    end

    assign rdata = empty ? '0 : mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/demux_n_stream.sv
// 1-to-CHANNELS streaming demux with per-channel FIFOs, all-or-nothing broadcast
// and a one-cycle drop pulse for out-of-range selects.
module demux_n_stream
    import demux_pkg::*;
#(
    parameter  int N        = 8,
    parameter  int CHANNELS = 4,
    parameter  int DEPTH    = 2,
    localparam int SEL_W    = sel_width(CHANNELS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N-1:0]          in_data,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic                  in_bcast,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [CHANNELS*N-1:0] out_data,
    output logic [CHANNELS-1:0]   out_valid,
    input  logic [CHANNELS-1:0]   out_ready,
    output logic                  drop_err
);
    localparam int NSEL = 1 << SEL_W;

    demux_mode_t           mode;
    logic [CHANNELS-1:0]   full, empty, push, pop;
    logic [NSEL-1:0]       full_pad, sel_ok;
    logic                  in_range, accept;
    logic                  drop_err_q, drop_err_d;

    assign mode = in_bcast ? MODE_BCAST : MODE_UNICAST;

    // Pad the select space to a power of two so unused codes decode as "drop".
    for (genvar i = 0; i < NSEL; i++) begin : g_pad
        if (i < CHANNELS) begin : g_real
            assign full_pad[i] = full[i];
            assign sel_ok[i]   = 1'b1;
        end else begin : g_void
            assign full_pad[i] = 1'b0;
            assign sel_ok[i]   = 1'b0;
        end
    end

    assign in_range = sel_ok[in_sel];

    always_comb begin
        in_ready = 1'b0;
        if (rst_n) begin
            case (mode)
                MODE_BCAST:   in_ready = ~|full;
                MODE_UNICAST: in_ready = !in_range || !full_pad[in_sel];
                default:      in_ready = 1'b0;
            endcase
        end
    end

    assign accept     = in_valid & in_ready;
    assign drop_err_d = accept & (mode == MODE_UNICAST) & ~in_range;

    always_ff @(posedge clk) begin
        if (!rst_n) drop_err_q <= 1'b0;
        else        drop_err_q <= drop_err_d;
    end

    assign drop_err = drop_err_q;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        assign push[c] = accept & ((mode == MODE_BCAST) | (in_range & (in_sel == SEL_W'(c))));
        assign pop[c]  = out_ready[c] & ~empty[c];

        sync_fifo #(
            .N     (N),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[c]),
            .pop   (pop[c]),
            .wdata (in_data),
            .rdata (out_data[c*N +: N]),
            .full  (full[c]),
            .empty (empty[c])
        );
    end

    assign out_valid = ~empty;

endmodule

// File: tb/tb_demux_n_stream.sv
// Directed bench: 4-channel instance for routing/backpressure/broadcast/reset,
// 3-channel instance for the out-of-range select drop.
module tb_demux_n_stream;
    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst_n;

    // 4-channel instance
    logic [7:0]  a_data;
    logic [1:0]  a_sel;
    logic        a_bcast, a_valid, a_ready, a_drop;
    logic [31:0] a_odata;
    logic [3:0]  a_ovalid, a_oready;

    // 3-channel instance
    logic [7:0]  b_data;
    logic [1:0]  b_sel;
    logic        b_bcast, b_valid, b_ready, b_drop;
    logic [23:0] b_odata;
    logic [2:0]  b_ovalid, b_oready;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    demux_n_stream #(.N(N), .CHANNELS(4), .DEPTH(2)) u_a (
        .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_sel(a_sel), .in_bcast(a_bcast),
        .in_valid(a_valid), .in_ready(a_ready), .out_data(a_odata), .out_valid(a_ovalid),
        .out_ready(a_oready), .drop_err(a_drop)
    );

    demux_n_stream #(.N(N), .CHANNELS(3), .DEPTH(2)) u_b (
        .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_sel(b_sel), .in_bcast(b_bcast),
        .in_valid(b_valid), .in_ready(b_ready), .out_data(b_odata), .out_valid(b_ovalid),
        .out_ready(b_oready), .drop_err(b_drop)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are driven and outputs sampled here.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0;
        a_data = 8'h77; a_sel = 2'd0; a_bcast = 1'b0; a_valid = 1'b1; a_oready = 4'b0;
        b_data = 8'h00; b_sel = 2'd0; b_bcast = 1'b0; b_valid = 1'b0; b_oready = 3'b0;

        // Reset held for two edges with in_valid asserted
        cyc(); cyc();
        chk("rst_out_valid", {28'b0, a_ovalid}, 32'h0);
        chk("rst_out_data",  a_odata, 32'h0);
        chk("rst_in_ready",  {31'b0, a_ready}, 32'h0);
        chk("rst_drop_err",  {31'b0, a_drop}, 32'h0);
        rst_n = 1'b1; a_valid = 1'b0;
        #1 chk("post_rst_in_ready", {31'b0, a_ready}, 32'h1);

        // Unicast routing and one-cycle latency
        a_valid = 1'b1; a_sel = 2'd2; a_data = 8'hA5;
        cyc();
        a_valid = 1'b0;
        #1;
        chk("uni_out_valid", {28'b0, a_ovalid}, 32'h4);
        chk("uni_out_data",  a_odata, 32'h00A5_0000);
        a_oready = 4'b0100;
        cyc();
        a_oready = 4'b0;
        chk("uni_popped", {28'b0, a_ovalid}, 32'h0);

        // Backpressure: fill channel 1
        a_valid = 1'b1; a_sel = 2'd1; a_data = 8'h11;
        cyc();
        a_data = 8'h22;
        cyc();
        a_data = 8'h33;
        #1 chk("full_ch1_ready", {31'b0, a_ready}, 32'h0);
        a_sel = 2'd0;
        #1 chk("free_ch0_ready", {31'b0, a_ready}, 32'h1);
        a_valid = 1'b0;
        chk("full_head0", {24'b0, a_odata[15:8]}, 32'h11);
        chk("full_valid", {28'b0, a_ovalid}, 32'h2);
        a_oready = 4'b0010;
        cyc();
        chk("fifo_head1", {24'b0, a_odata[15:8]}, 32'h22);
        cyc();
        chk("fifo_drained", {28'b0, a_ovalid}, 32'h0);

        // Wrap-around: ten streaming pushes with concurrent pops on channel 1
        a_sel = 2'd1; a_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a_data = 8'h40 + 8'(i);
            cyc();
            chk($sformatf("wrap_head_%0d", i), {24'b0, a_odata[15:8]}, 32'h40 + i);
        end
        a_valid = 1'b0;
        cyc();
        a_oready = 4'b0;
        chk("wrap_empty", {28'b0, a_ovalid}, 32'h0);

        // Broadcast is all-or-nothing
        a_valid = 1'b1; a_sel = 2'd3; a_data = 8'h31;
        cyc();
        a_data = 8'h32;
        cyc();
        a_bcast = 1'b1; a_data = 8'h5C;
        #1 chk("bcast_blocked_ready", {31'b0, a_ready}, 32'h0);
        cyc();
        chk("bcast_no_partial", {28'b0, a_ovalid}, 32'h8);
        chk("bcast_ch3_head", {24'b0, a_odata[31:24]}, 32'h31);
        a_oready = 4'b1000;
        cyc();
        a_oready = 4'b0;
        #1 chk("bcast_ready_after_pop", {31'b0, a_ready}, 32'h1);
        cyc();
        a_valid = 1'b0; a_bcast = 1'b0;
        chk("bcast_all_valid", {28'b0, a_ovalid}, 32'hF);
        chk("bcast_all_data",  a_odata, 32'h325C_5C5C);
        a_oready = 4'b1000;
        cyc();
        a_oready = 4'b0;
        chk("bcast_ch3_tail", {24'b0, a_odata[31:24]}, 32'h5C);
        chk("a_no_drop", {31'b0, a_drop}, 32'h0);

        // Reset mid-operation discards everything
        rst_n = 1'b0;
        #1 chk("midrst_ready", {31'b0, a_ready}, 32'h0);
        cyc();
        rst_n = 1'b1;
        chk("midrst_valid", {28'b0, a_ovalid}, 32'h0);
        chk("midrst_data",  a_odata, 32'h0);
        a_valid = 1'b1; a_sel = 2'd0; a_data = 8'h99;
        cyc();
        a_data = 8'h9A;
        chk("post_rst_push", a_odata, 32'h0000_0099);
        cyc();
        a_valid = 1'b0;
        chk("post_rst_full", {31'b0, a_ready}, 32'h0);

        // Out-of-range select on the 3-channel instance
        b_valid = 1'b1; b_sel = 2'd3; b_data = 8'hFF;
        #1 chk("oor_ready", {31'b0, b_ready}, 32'h1);
        cyc();
        b_valid = 1'b0;
        chk("oor_drop_pulse", {31'b0, b_drop}, 32'h1);
        chk("oor_no_valid", {29'b0, b_ovalid}, 32'h0);
        cyc();
        chk("oor_drop_clear", {31'b0, b_drop}, 32'h0);
        b_valid = 1'b1; b_sel = 2'd2; b_data = 8'h6E;
        cyc();
        b_valid = 1'b0;
        chk("b_inrange_valid", {29'b0, b_ovalid}, 32'h4);
        chk("b_inrange_data", {8'b0, b_odata}, 32'h006E_0000);
        chk("b_inrange_nodrop", {31'b0, b_drop}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
